// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and table entry.
package bp_pkg;

    // Widest address the entry fields can hold; instantiate with XLEN <= BP_XLEN.
    localparam int BP_XLEN = 32;

    // Saturating direction counter; MSB set means predict taken.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // One direct-mapped table slot. Tag is stored zero-extended to BP_XLEN.
    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        ctr_t               ctr;
        logic               is_jump;
        logic [BP_XLEN-1:0] target;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for one 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    input  logic force_st_i,
    output ctr_t ctr_o
);

    // Jumps pin the counter to strongly-taken; otherwise step and saturate.
    always_comb begin
        ctr_o = ctr_i;
        if (force_st_i) begin
            ctr_o = ST;
        end else if (taken_i) begin
            unique case (ctr_i)
                SNT:     ctr_o = WNT;
                WNT:     ctr_o = WT;
                WT:      ctr_o = ST;
                default: ctr_o = ST;
            endcase
        end else begin
            unique case (ctr_i)
                ST:      ctr_o = WT;
                WT:      ctr_o = WNT;
                WNT:     ctr_o = SNT;
                default: ctr_o = SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, zero-latency lookup,
// single-port update from execute, and resolution statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [XLEN-1:0] pred_npc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    input  logic            flush,
    output logic            mispredict,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);

    bp_entry_t tbl_q [ENTRIES];
    bp_entry_t tbl_d [ENTRIES];
    logic [31:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    // Lookup side: reads the registered table only, so a same-cycle update
    // to the same index is not visible until the next cycle.
    logic [IDX-1:0]     p_idx;
    logic [BP_XLEN-1:0] p_tag;
    bp_entry_t          p_ent;
    logic               p_hit;

    assign p_idx = pred_pc[IDX+1:2];
    assign p_tag = BP_XLEN'(pred_pc[XLEN-1:IDX+2]);
    assign p_ent = tbl_q[p_idx];
    assign p_hit = p_ent.valid && (p_ent.tag == p_tag);

    assign pred_taken  = p_hit && ((p_ent.ctr == WT) || (p_ent.ctr == ST) || p_ent.is_jump);
    assign pred_target = p_hit ? p_ent.target[XLEN-1:0] : '0;
    assign pred_npc    = pred_taken ? pred_target : pred_pc + XLEN'(4);

    // Update side. Targets are halfword aligned, so bit 0 is dropped everywhere.
    logic [IDX-1:0]     u_idx;
    logic [BP_XLEN-1:0] u_tag;
    bp_entry_t          u_ent;
    logic               u_hit;
    logic [XLEN-1:0]    u_tgt;
    ctr_t               ctr_nxt;

    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = BP_XLEN'(upd_pc[XLEN-1:IDX+2]);
    assign u_ent = tbl_q[u_idx];
    assign u_hit = u_ent.valid && (u_ent.tag == u_tag);
    assign u_tgt = upd_target & ~XLEN'(1);

    assign mispredict = upd_valid &&
        ((upd_pred_taken != upd_taken) || (upd_taken && (upd_pred_target != u_tgt)));

    bp_sat_counter u_ctr (
        .ctr_i      (u_ent.ctr),
        .taken_i    (upd_taken),
        .force_st_i (upd_is_jump),
        .ctr_o      (ctr_nxt)
    );

    // Next table state: flush beats update; taken misses allocate, others are dropped.
    always_comb begin
        tbl_d = tbl_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) tbl_d[i].valid = 1'b0;
        end else if (upd_valid) begin
            if (u_hit) begin
                tbl_d[u_idx].ctr     = ctr_nxt;
                tbl_d[u_idx].is_jump = upd_is_jump;
                if (upd_taken) tbl_d[u_idx].target = BP_XLEN'(u_tgt);
            end else if (upd_taken) begin
                tbl_d[u_idx].valid   = 1'b1;
                tbl_d[u_idx].tag     = u_tag;
                tbl_d[u_idx].is_jump = upd_is_jump;
                tbl_d[u_idx].target  = BP_XLEN'(u_tgt);
                if (upd_is_jump) tbl_d[u_idx].ctr = ST;
                else             tbl_d[u_idx].ctr = WT;
            end
        end
    end

    // Statistics count every resolution, including one that coincides with a flush.
    always_comb begin
        bcnt_d = bcnt_q + 32'(upd_valid);
        mcnt_d = mcnt_q + 32'(mispredict);
    end

    // State registers; reset clears the whole table, not just the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            tbl_q  <= tbl_d;
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
        end
    end

    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (XLEN=32, ENTRIES=64).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target, pred_npc;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken, flush;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] branch_count, mispredict_count;

    branch_predictor #(.XLEN(32), .ENTRIES(64)) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_npc(pred_npc), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_is_jump(upd_is_jump), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .flush(flush), .mispredict(mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference table (index pc[7:2], tag pc[31:8]).
    logic        m_v [64];
    logic [23:0] m_tag [64];
    logic [1:0]  m_c [64];
    logic        m_j [64];
    logic [31:0] m_t [64];
    logic [31:0] m_bc, m_mc;

    typedef struct packed {
        logic        t;
        logic [31:0] tg;
        logic [31:0] npc;
        logic        mp;
    } exp_t;
    exp_t sbq[$];

    task automatic m_clear();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 1'b0; m_tag[i] = '0; m_c[i] = 2'b00; m_j[i] = 1'b0; m_t[i] = '0;
        end
        m_bc = '0; m_mc = '0;
    endtask

    function automatic logic m_hit(input logic [31:0] pc);
        return m_v[pc[7:2]] && (m_tag[pc[7:2]] == pc[31:8]);
    endfunction

    function automatic logic m_misp(input logic uv, input logic ut, input logic [31:0] utg,
                                    input logic upt, input logic [31:0] uptg);
        return uv && ((upt != ut) || (ut && (uptg != {utg[31:1], 1'b0})));
    endfunction

    // Apply one edge of the reference model using the inputs currently driven.
    task automatic m_edge();
        logic [5:0] i;
        logic mp;
        i  = upd_pc[7:2];
        mp = m_misp(upd_valid, upd_taken, upd_target, upd_pred_taken, upd_pred_target);
        if (rst) begin
            m_clear();
        end else begin
            m_bc = m_bc + 32'(upd_valid);
            m_mc = m_mc + 32'(mp);
            if (flush) begin
                for (int k = 0; k < 64; k++) m_v[k] = 1'b0;
            end else if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (upd_is_jump)    m_c[i] = 2'b11;
                    else if (upd_taken) m_c[i] = (m_c[i] == 2'b11) ? 2'b11 : m_c[i] + 2'b01;
                    else                m_c[i] = (m_c[i] == 2'b00) ? 2'b00 : m_c[i] - 2'b01;
                    m_j[i] = upd_is_jump;
                    if (upd_taken) m_t[i] = {upd_target[31:1], 1'b0};
                end else if (upd_taken) begin
                    m_v[i] = 1'b1; m_tag[i] = upd_pc[31:8]; m_j[i] = upd_is_jump;
                    m_t[i] = {upd_target[31:1], 1'b0};
                    m_c[i] = upd_is_jump ? 2'b11 : 2'b10;
                end
            end
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, check counters.
    task automatic step(input logic r, input logic f, input logic [31:0] ppc,
                        input logic uv, input logic [31:0] upc, input logic uj,
                        input logic ut, input logic [31:0] utg,
                        input logic upt, input logic [31:0] uptg);
        exp_t e, o;
        logic [5:0] pi;
        @(negedge clk);
        rst = r; flush = f; pred_pc = ppc; upd_valid = uv; upd_pc = upc;
        upd_is_jump = uj; upd_taken = ut; upd_target = utg;
        upd_pred_taken = upt; upd_pred_target = uptg;
        #1;
        pi    = ppc[7:2];
        e.t   = m_hit(ppc) && (m_c[pi][1] || m_j[pi]);
        e.tg  = m_hit(ppc) ? m_t[pi] : 32'h0;
        e.npc = e.t ? e.tg : ppc + 32'd4;
        e.mp  = m_misp(uv, ut, utg, upt, uptg);
        sbq.push_back(e);
        o = sbq.pop_front();
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, o.t});
        chk("pred_target", pred_target, o.tg);
        chk("pred_npc", pred_npc, o.npc);
        chk("mispredict", {31'b0, mispredict}, {31'b0, o.mp});
        @(posedge clk);
        m_edge();
        #1;
        chk("branch_count", branch_count, m_bc);
        chk("mispredict_count", mispredict_count, m_mc);
    endtask

    task automatic idle(input logic [31:0] ppc);
        step(1'b0, 1'b0, ppc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic uj, input logic ut,
                       input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
        step(1'b0, 1'b0, upc, 1'b1, upc, uj, ut, utg, upt, uptg);
    endtask

    logic [31:0] pcs [6];
    logic [31:0] bc0, mc0, rp, rt;
    logic        rtk;

    initial begin
        m_clear();
        rst = 1'b1; flush = 1'b0; pred_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
        upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;

        // Reset with an update in flight: update must be discarded.
        step(1'b1, 1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("rst_npc", pred_npc, 32'h104);
        chk("rst_target", pred_target, 32'h0);
        idle(32'h100);
        chk("rst_discard_taken", {31'b0, pred_taken}, 32'h0);

        // Taken branch then two not-taken: WT -> WNT -> SNT.
        upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        idle(32'h100);
        chk("br_npc", pred_npc, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(32'h100);
        chk("br_nt_taken", {31'b0, pred_taken}, 32'h0);

        // jalr with odd target: aligned storage, ST survives one not-taken.
        upd(32'h200, 1'b1, 1'b1, 32'h301, 1'b0, 32'h0);
        idle(32'h200);
        chk("jalr_target", pred_target, 32'h300);
        upd(32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        idle(32'h200);
        chk("jalr_still_taken", {31'b0, pred_taken}, 32'h1);

        // Aliasing: same index, different tag; not-taken miss leaves table alone.
        step(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        upd(32'h200, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        upd(32'h400, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(32'h100);
        chk("alias_old_miss", {31'b0, pred_taken}, 32'h0);
        idle(32'h200);
        chk("alias_new_hit", pred_target, 32'h500);

        // Same-index prediction and update in one cycle sees old contents.
        step(1'b0, 1'b0, 32'h204, 1'b1, 32'h204, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);

        // Four updates, two mispredicted; then flush with an update.
        bc0 = branch_count; mc0 = mispredict_count;
        upd(32'h10, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
        upd(32'h14, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        upd(32'h18, 1'b0, 1'b1, 32'h30, 1'b0, 32'h0);
        upd(32'h1c, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stat_branches", branch_count - bc0, 32'd4);
        chk("stat_misp", mispredict_count - mc0, 32'd2);
        bc0 = branch_count;
        step(1'b0, 1'b1, 32'h10, 1'b1, 32'h200, 1'b0, 1'b1, 32'h900, 1'b0, 32'h0);
        chk("flush_counts", branch_count - bc0, 32'd1);
        idle(32'h200);
        chk("flush_invalid", {31'b0, pred_taken}, 32'h0);

        // Random traffic over a few aliasing PCs.
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h400;
        pcs[3] = 32'h104; pcs[4] = 32'h1000; pcs[5] = 32'hfffffffc;
        for (int n = 0; n < 80; n++) begin
            rp  = pcs[$urandom_range(0, 5)];
            rt  = $urandom;
            rtk = 1'($urandom_range(0, 1));
            step(1'b0, ($urandom_range(0, 15) == 0), pcs[$urandom_range(0, 5)],
                 1'($urandom_range(0, 3) != 0), rp, ($urandom_range(0, 5) == 0), rtk, rt,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? {rt[31:1], 1'b0} : $urandom);
        end

        // Asynchronous reset clears state without waiting for an edge.
        upd(32'h300, 1'b0, 1'b1, 32'h800, 1'b0, 32'h0);
        @(negedge clk);
        upd_valid = 1'b0; pred_pc = 32'h300;
        #1;
        chk("pre_arst_taken", {31'b0, pred_taken}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_taken", {31'b0, pred_taken}, 32'h0);
        chk("arst_npc", pred_npc, 32'h304);
        chk("arst_bcnt", branch_count, 32'h0);
        m_clear();
        idle(32'h300);
        chk("post_arst_miss", {31'b0, pred_taken}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, 32, address/data width in bits.
REQ-002 Parameter ENTRIES, 64, number of direct-mapped predictor entries; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port pred_pc  input  XLEN  fetch-stage PC to predict.
REQ-006 Port pred_taken  output  1  prediction for pred_pc is taken.
REQ-007 Port pred_target  output  XLEN  predicted target; 0 on miss.
REQ-008 Port pred_npc  output  XLEN  predicted next PC.
REQ-009 Port upd_valid  input  1  execute-stage resolution strobe.
REQ-010 Port upd_pc  input  XLEN  PC of the resolved control instruction.
REQ-011 Port upd_is_jump  input  1  instruction is jal/jalr (always taken).
REQ-012 Port upd_taken  input  1  resolved direction.
REQ-013 Port upd_target  input  XLEN  resolved target.
REQ-014 Port upd_pred_taken  input  1  prediction originally issued for this instruction.
REQ-015 Port upd_pred_target  input  XLEN  target originally predicted.
REQ-016 Port flush  input  1  synchronous clear of all entries.
REQ-017 Port mispredict  output  1  resolution disagrees with the issued prediction.
REQ-018 Port branch_count  output  32  number of resolved updates.
REQ-019 Port mispredict_count  output  32  number of mispredicted updates.

Function
REQ-020 Index = pc[IDX+1:2] with IDX = log2(ENTRIES); tag = pc[XLEN-1:IDX+2]; each entry SHALL hold valid, tag, 2-bit counter, is_jump, and an XLEN-bit target.
REQ-021 Prediction SHALL be combinational (zero latency): hit = valid & tag match; pred_taken = hit & (counter[1] | is_jump); pred_target = hit ? stored target : 0; pred_npc = pred_taken ? pred_target : pred_pc + 4 (modulo 2^XLEN).
REQ-022 Counter states SHALL be SNT=00, WNT=01, WT=10, ST=11; taken saturates upward at ST, not-taken saturates downward at SNT.
REQ-023 An update with upd_valid=1 that hits SHALL step the counter, overwrite is_jump, and, if upd_taken=1, overwrite the target.
REQ-024 An update that misses with upd_taken=1 SHALL allocate the entry (replacing any previous occupant): valid=1, new tag, target, is_jump, counter=WT.
REQ-025 An update that misses with upd_taken=0 SHALL leave the table unchanged.
REQ-026 When upd_is_jump=1, the counter SHALL be written to ST regardless of its prior state.
REQ-027 Stored targets SHALL have bit 0 forced to 0.
REQ-028 mispredict (combinational) = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & (upd_pred_target != {upd_target[XLEN-1:1],1'b0}))).
REQ-029 branch_count SHALL increment on each upd_valid=1 cycle; mispredict_count SHALL increment on each mispredict=1 cycle; both wrap at 2^32.
REQ-030 When prediction and update target the same index in one cycle, the prediction SHALL use pre-update contents; no bypass.
REQ-031 flush=1 SHALL clear all valid bits at the next edge and SHALL take priority over a simultaneous update; the statistics counters still count that update.

Reset
REQ-032 rst=1 SHALL immediately clear all valid bits, all counters to SNT, and branch_count/mispredict_count to 0; consequently pred_taken=0, pred_target=0, and pred_npc=pred_pc+4.
REQ-033 Reset asserted during an update SHALL discard that update; the table SHALL be fully predictable from the first edge after rst deasserts.

Structure
REQ-034 Package bp_pkg SHALL hold the 2-bit counter typedef, the SNT/WNT/WT/ST constants, and the entry struct typedef.
REQ-035 Saturating counter next-state logic SHALL be a sub-module named bp_sat_counter; the table SHALL be flop-based, not SRAM.

Verification
REQ-036 Reset, then pred_pc=0x100 -> pred_taken=0, pred_target=0, pred_npc=0x104.
REQ-037 Taken branch update at pc=0x100, target=0x80 -> next cycle pred_pc=0x100 gives pred_taken=1, pred_npc=0x80; two not-taken updates -> pred_taken=0 (WT->WNT->SNT).
REQ-038 jalr update at pc=0x200, target=0x301, is_jump=1 -> stored target 0x300; counter ST; predict taken after any single later not-taken update.
REQ-039 ENTRIES=64: taken update at 0x100, then taken update at 0x200 (same index, different tag) -> 0x100 misses and 0x200 hits; not-taken miss at 0x400 leaves the table unchanged.
REQ-040 Four updates with upd_pred_taken mismatching on two of them -> branch_count=4, mispredict_count=2; flush asserted with a simultaneous update -> all entries invalid, branch_count increments.
